// File: rtl/freq_meter_pkg.sv
// Shared types, range codes and gate-length helpers for the gated-counting frequency meter.
package freq_meter_pkg;

   typedef enum logic [1:0] {WARMUP, CLEAR, GATE, LATCH} state_t;

   localparam logic [1:0] RANGE_1S    = 2'd0;
   localparam logic [1:0] RANGE_100MS = 2'd1;
   localparam logic [1:0] RANGE_10MS  = 2'd2;
   localparam logic [1:0] RANGE_1MS   = 2'd3;

   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t BCD_NINE = 4'd9;

   function automatic int gate_cycles(input int clk_hz, input logic [1:0] range_sel);
      int result;
      case (range_sel)
         RANGE_1S:    result = clk_hz;
         RANGE_100MS: result = clk_hz / 10;
         RANGE_10MS:  result = clk_hz / 100;
         default:     result = clk_hz / 1000;
      endcase
      return result;
   endfunction

   function automatic int gate_cnt_width(input int clk_hz);
      return $clog2(clk_hz);
   endfunction

endpackage

// File: rtl/freq_bcd_counter.sv
// DIGITS-wide saturating BCD counter: clr zeroes, inc adds one, an increment at all-9s
// holds the value and raises a sticky ovf until the next clr.
module freq_bcd_counter
   import freq_meter_pkg::*;
#(
   parameter int DIGITS = 6
)
(
   input  logic                clk,
   input  logic                srst,
   input  logic                clr,
   input  logic                inc,
   output logic [4*DIGITS-1:0] count,
   output logic                ovf
);

   bcd_digit_t        digit_reg [DIGITS];
   logic [DIGITS-1:0] nine;
   logic [DIGITS-1:0] carry;
   logic              sat;
   logic              ovf_reg;

   assign sat = inc && (&nine);
   assign ovf = ovf_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         // A digit steps when every lower digit is 9, i.e. the carry ripples into it.
         localparam logic [DIGITS-1:0] LOW_MASK = (DIGITS'(1) << gi) - DIGITS'(1);

         assign nine[gi]         = (digit_reg[gi] == BCD_NINE);
         assign carry[gi]        = inc && ((nine & LOW_MASK) == LOW_MASK);
         assign count[4*gi +: 4] = digit_reg[gi];

         always_ff @(posedge clk) begin
            if (srst || clr) begin
               digit_reg[gi] <= '0;
            end else if (carry[gi] && !sat) begin
               digit_reg[gi] <= nine[gi] ? 4'd0 : digit_reg[gi] + 4'd1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (srst || clr) begin
         ovf_reg <= 1'b0;
      end else if (sat) begin
         ovf_reg <= 1'b1;
      end
   end

endmodule

// File: rtl/freq_meter_core.sv
// Gated-counting frequency meter core: synchronised edge count over a decade gate window.
// Optional AUTORANGE_EN replaces the range port with self-adjusting range selection.
module freq_meter_core
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ      = 50000000,
   parameter int DIGITS      = 6,
   parameter int SYNC_STAGES = 2
)
(
   input  logic                clock,
   input  logic                reset,
   input  logic                clock_text,
   input  logic [1:0]          range,
   input  logic                hold,
   output logic [4*DIGITS-1:0] bcd,
   output logic [1:0]          dp_pos,
   output logic                overflow,
   output logic                valid
);

   localparam int GATE_W = gate_cnt_width(CLK_HZ);
   localparam int WARM_W = $clog2(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   delay_reg;
   logic                   rise;
   state_t                 state_reg;
   logic [WARM_W-1:0]      warm_cnt_reg;
   logic [GATE_W-1:0]      gate_cnt_reg;
   logic [1:0]             range_q;
   logic [1:0]             sel_range;
   logic [4*DIGITS-1:0]    count;
   logic                   ovf;
   logic [4*DIGITS-1:0]    bcd_reg;
   logic [1:0]             dp_pos_reg;
   logic                   overflow_reg;
   logic                   valid_reg;

`ifdef AUTORANGE_EN
   logic unused_range;
   assign unused_range = ^range;
   assign sel_range    = range_q;
`else
   assign sel_range    = range;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_reg  <= '0;
         delay_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], clock_text};
         delay_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign rise = sync_reg[SYNC_STAGES-1] & ~delay_reg;

   freq_bcd_counter #(.DIGITS(DIGITS)) u_counter (
      .clk   (clock),
      .srst  (reset),
      .clr   (state_reg == CLEAR),
      .inc   ((state_reg == GATE) && rise),
      .count (count),
      .ovf   (ovf)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= WARMUP;
         warm_cnt_reg <= '0;
         gate_cnt_reg <= '0;
         range_q      <= RANGE_1S;
         bcd_reg      <= '0;
         dp_pos_reg   <= '0;
         overflow_reg <= 1'b0;
         valid_reg    <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            WARMUP: begin
               // Lets the synchroniser fill so power-up junk never reaches the counter.
               if (warm_cnt_reg == WARM_W'(SYNC_STAGES)) begin
                  state_reg <= CLEAR;
               end else begin
                  warm_cnt_reg <= warm_cnt_reg + WARM_W'(1);
               end
            end
            CLEAR: begin
               gate_cnt_reg <= GATE_W'(gate_cycles(CLK_HZ, sel_range) - 1);
`ifndef AUTORANGE_EN
               range_q      <= range;
`endif
               state_reg    <= GATE;
            end
            GATE: begin
               if (gate_cnt_reg == '0) begin
                  state_reg <= LATCH;
               end else begin
                  gate_cnt_reg <= gate_cnt_reg - GATE_W'(1);
               end
            end
            LATCH: begin
               if (!hold) begin
                  bcd_reg      <= count;
                  overflow_reg <= ovf;
                  dp_pos_reg   <= range_q;
                  valid_reg    <= 1'b1;
               end
`ifdef AUTORANGE_EN
               // Up on saturation, down when the top two digits are idle; the gap is the hysteresis.
               if (ovf && (range_q != RANGE_1MS)) begin
                  range_q <= range_q + 2'd1;
               end else if ((count[4*DIGITS-1 -: 8] == 8'd0) && (range_q != RANGE_1S)) begin
                  range_q <= range_q - 2'd1;
               end
`endif
               state_reg <= CLEAR;
            end
            default: state_reg <= WARMUP;
         endcase
      end
   end

   assign bcd      = bcd_reg;
   assign dp_pos   = dp_pos_reg;
   assign overflow = overflow_reg;
   assign valid    = valid_reg;

endmodule

// File: tb/tb_freq_meter_core.sv
// Directed bench for freq_meter_core at CLK_HZ=10000, DIGITS=3, SYNC_STAGES=2.
// Build with AUTORANGE_EN defined to exercise the autorange scenario instead of the range-port ones.
module tb_freq_meter_core;

   localparam int CLK_HZ      = 10000;
   localparam int DIGITS      = 3;
   localparam int SYNC_STAGES = 2;

   logic                clock      = 1'b0;
   logic                reset      = 1'b1;
   logic                clock_text = 1'b0;
   logic [1:0]          range      = 2'd0;
   logic                hold       = 1'b0;
   logic [4*DIGITS-1:0] bcd;
   logic [1:0]          dp_pos;
   logic                overflow;
   logic                valid;

   int errors = 0;
   int checks = 0;

   // Input generator state: period/restart_seq written by the stimulus, phase/seen_seq by the generator.
   int period      = 20;
   int restart_seq = 0;
   int seen_seq    = 0;
   int phase       = 0;

   freq_meter_core #(
      .CLK_HZ      (CLK_HZ),
      .DIGITS      (DIGITS),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .clock_text (clock_text),
      .range      (range),
      .hold       (hold),
      .bcd        (bcd),
      .dp_pos     (dp_pos),
      .overflow   (overflow),
      .valid      (valid)
   );

   always #5 clock = ~clock;

   // Square wave high for the first half of each period; a restart begins a fresh high half.
   always @(negedge clock) begin
      if (restart_seq != seen_seq) begin
         seen_seq = restart_seq;
         phase    = 0;
      end else begin
         phase = phase + 1;
         if (phase >= period) phase = 0;
      end
      clock_text = (phase < period / 2);
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic set_input(input int p, input bit restart);
      period = p;
      if (restart) restart_seq = restart_seq + 1;
   endtask

   task automatic wait_valid(input int limit, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while ((n < limit) && !ok) begin
         step();
         n = n + 1;
         if (valid === 1'b1) ok = 1'b1;
      end
      if (ok)
         $display("valid after %0d cycles: bcd=%03h dp_pos=%0d overflow=%b", n, bcd, dp_pos, overflow);
      else
         $display("no valid within %0d cycles", limit);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) step();
      checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %03h, expected 000", bcd); end
      checks++; if (dp_pos !== 2'd0) begin errors++; $display("FAIL reset_dp_pos: got %0d, expected 0", dp_pos); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid); end
   endtask

`ifdef AUTORANGE_EN

   task automatic test_autorange;
      int n;
      bit ok;
      range = 2'd3;
      set_input(2, 1'b0);
      reset = 1'b0;
      wait_valid(10100, n, ok);
      checks++; if (!ok || n !== 10005) begin errors++; $display("FAIL auto_w1_latency: got %0d cycles, expected 10005", n); end
      checks++; if (bcd !== 12'h999) begin errors++; $display("FAIL auto_w1_bcd: got %03h, expected 999", bcd); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL auto_w1_overflow: got %b, expected 1", overflow); end
      checks++; if (dp_pos !== 2'd0) begin errors++; $display("FAIL auto_w1_dp_pos: got %0d, expected 0", dp_pos); end

      wait_valid(1060, n, ok);
      checks++; if (!ok || n !== 1002) begin errors++; $display("FAIL auto_w2_latency: got %0d cycles, expected 1002", n); end
      checks++; if (bcd !== 12'h500) begin errors++; $display("FAIL auto_w2_bcd: got %03h, expected 500", bcd); end
      checks++; if (dp_pos !== 2'd1) begin errors++; $display("FAIL auto_w2_dp_pos: got %0d, expected 1", dp_pos); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL auto_w2_overflow: got %b, expected 0", overflow); end

      set_input(200, 1'b1);
      wait_valid(1060, n, ok);
      checks++; if (!ok || n !== 1002) begin errors++; $display("FAIL auto_w3_latency: got %0d cycles, expected 1002", n); end
      checks++; if (bcd !== 12'h005) begin errors++; $display("FAIL auto_w3_bcd: got %03h, expected 005", bcd); end
      checks++; if (dp_pos !== 2'd1) begin errors++; $display("FAIL auto_w3_dp_pos: got %0d, expected 1", dp_pos); end

      wait_valid(10100, n, ok);
      checks++; if (!ok || n !== 10002) begin errors++; $display("FAIL auto_w4_latency: got %0d cycles, expected 10002", n); end
      checks++; if (bcd !== 12'h050) begin errors++; $display("FAIL auto_w4_bcd: got %03h, expected 050", bcd); end
      checks++; if (dp_pos !== 2'd0) begin errors++; $display("FAIL auto_w4_dp_pos: got %0d, expected 0", dp_pos); end
   endtask

`else

   task automatic test_range0;
      int n;
      bit ok;
      reset = 1'b0;
      wait_valid(10100, n, ok);
      checks++; if (!ok || n !== 10005) begin errors++; $display("FAIL first_valid_latency: got %0d cycles, expected 10005", n); end
      checks++; if (bcd !== 12'h500) begin errors++; $display("FAIL range0_bcd: got %03h, expected 500", bcd); end
      checks++; if (dp_pos !== 2'd0) begin errors++; $display("FAIL range0_dp_pos: got %0d, expected 0", dp_pos); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL range0_overflow: got %b, expected 0", overflow); end
   endtask

   task automatic test_range1;
      int n;
      bit ok;
      range = 2'd1;
      step();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b one cycle later, expected 0", valid); end
      wait_valid(1060, n, ok);
      checks++; if (!ok || (n + 1) !== 1002) begin errors++; $display("FAIL range1_w1_period: got %0d cycles, expected 1002", n + 1); end
      checks++; if (bcd !== 12'h050) begin errors++; $display("FAIL range1_w1_bcd: got %03h, expected 050", bcd); end
      checks++; if (dp_pos !== 2'd1) begin errors++; $display("FAIL range1_w1_dp_pos: got %0d, expected 1", dp_pos); end
      wait_valid(1060, n, ok);
      checks++; if (!ok || n !== 1002) begin errors++; $display("FAIL range1_w2_period: got %0d cycles, expected 1002", n); end
      checks++; if (bcd !== 12'h050) begin errors++; $display("FAIL range1_w2_bcd: got %03h, expected 050", bcd); end
      checks++; if (dp_pos !== 2'd1) begin errors++; $display("FAIL range1_w2_dp_pos: got %0d, expected 1", dp_pos); end
   endtask

   task automatic test_overflow;
      int n;
      bit ok;
      range = 2'd0;
      set_input(2, 1'b1);
      wait_valid(10100, n, ok);
      checks++; if (!ok || n !== 10002) begin errors++; $display("FAIL ovf_period: got %0d cycles, expected 10002", n); end
      checks++; if (bcd !== 12'h999) begin errors++; $display("FAIL ovf_bcd: got %03h, expected 999", bcd); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
      checks++; if (dp_pos !== 2'd0) begin errors++; $display("FAIL ovf_dp_pos: got %0d, expected 0", dp_pos); end
      set_input(20, 1'b1);
      wait_valid(10100, n, ok);
      checks++; if (!ok || n !== 10002) begin errors++; $display("FAIL recover_period: got %0d cycles, expected 10002", n); end
      checks++; if (bcd !== 12'h500) begin errors++; $display("FAIL recover_bcd: got %03h, expected 500", bcd); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL recover_overflow: got %b, expected 0", overflow); end
   endtask

   task automatic test_hold;
      int n;
      int seen;
      bit ok;
      range = 2'd1;
      hold  = 1'b1;
      set_input(40, 1'b1);
      seen = 0;
      for (int i = 0; i < 1002; i++) begin
         step();
         if (valid !== 1'b0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL hold_no_valid: got %0d pulses, expected 0", seen); end
      checks++; if (bcd !== 12'h500) begin errors++; $display("FAIL hold_bcd: got %03h, expected 500", bcd); end
      checks++; if (dp_pos !== 2'd0) begin errors++; $display("FAIL hold_dp_pos: got %0d, expected 0", dp_pos); end
      hold = 1'b0;
      wait_valid(1060, n, ok);
      checks++; if (!ok || n !== 1002) begin errors++; $display("FAIL unhold_period: got %0d cycles, expected 1002", n); end
      checks++; if (bcd !== 12'h025) begin errors++; $display("FAIL unhold_bcd: got %03h, expected 025", bcd); end
      checks++; if (dp_pos !== 2'd1) begin errors++; $display("FAIL unhold_dp_pos: got %0d, expected 1", dp_pos); end
   endtask

   task automatic test_mid_reset;
      int n;
      bit ok;
      range = 2'd0;
      set_input(20, 1'b0);
      repeat (500) step();
      reset = 1'b1;
      step();
      checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL midreset_bcd: got %03h, expected 000", bcd); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, expected 0", valid); end
      checks++; if (dp_pos !== 2'd0) begin errors++; $display("FAIL midreset_dp_pos: got %0d, expected 0", dp_pos); end
      reset = 1'b0;
      wait_valid(10100, n, ok);
      checks++; if (!ok || n !== 10005) begin errors++; $display("FAIL midreset_latency: got %0d cycles, expected 10005", n); end
      checks++; if (bcd !== 12'h500) begin errors++; $display("FAIL midreset_result: got %03h, expected 500", bcd); end
   endtask

`endif

   initial begin
`ifdef AUTORANGE_EN
      set_input(2, 1'b0);
      test_reset();
      test_autorange();
`else
      test_reset();
      test_range0();
      test_range1();
      test_overflow();
      test_hold();
      test_mid_reset();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
